// File: rtl/shift_pin_sout_fsm_if.sv
// Bundles the host-side control/data signals and the serial-transmit status
// of shift_pin_sout_fsm.
//   master : drives select, load, din, shift, clr_ovr; observes status
//   slave  : the transmitter itself (consumes controls, drives status)
// Signals:
//   select    - qualifies load, shift and clr_ovr
//   load      - write din into the holding register
//   din       - parallel word, index 0 is transmitted first
//   shift     - advance the serial output by one bit
//   clr_ovr   - clear the sticky overrun flag
//   sout      - serial data out (registered)
//   busy      - a word is being shifted out
//   hold_full - holding register occupied
//   done      - one-cycle pulse after the last bit of a word
//   overrun   - sticky, a load was dropped
interface shift_pin_sout_fsm_if #(
    parameter int WIDTH = 8
);
    logic               select;
    logic               load;
    logic [0:WIDTH-1]   din;
    logic               shift;
    logic               clr_ovr;
    logic               sout;
    logic               busy;
    logic               hold_full;
    logic               done;
    logic               overrun;

    modport master (
        output select, load, din, shift, clr_ovr,
        input  sout, busy, hold_full, done, overrun
    );

    modport slave (
        input  select, load, din, shift, clr_ovr,
        output sout, busy, hold_full, done, overrun
    );
endinterface

// File: rtl/shift_pin_sout_fsm.sv
// Parallel-in / serial-out transmitter with a one-word holding register.
// A word written into the holding register is moved into the shift register
// as soon as the shifter is free (IDLE) or on the final shift of the current
// word, giving gap-free back-to-back transmission. Bit index 0 leaves first.
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous, active-high, dominates every other input
//   bus   - shift_pin_sout_fsm_if.slave (controls in, status out)
module shift_pin_sout_fsm #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_pin_sout_fsm_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [0:WIDTH-1]   hold_q, hold_d;
    logic [0:WIDTH-1]   shift_q, shift_d;
    logic [0:WIDTH-1]   shift_adv;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hold_full_q, hold_full_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;

    logic               load_req;
    logic               shift_req;
    logic               last_shift;
    logic               xfer;
    logic               load_ok;
    logic               load_drop;

    // Shift toward index 0 so sout always presents shift_q[0]; zero fills in.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_adv
            assign shift_adv[gi] = shift_q[gi + 1];
        end
    endgenerate
    assign shift_adv[WIDTH-1] = 1'b0;

    assign load_req   = bus.select & bus.load;
    assign shift_req  = bus.select & bus.shift;
    assign last_shift = (state_q == ST_SHIFT) && shift_req && (cnt_q == CNT_LAST);
    // The holding register empties whenever the shifter can take its word.
    assign xfer       = hold_full_q && ((state_q == ST_IDLE) || last_shift);
    // A load is only dropped when the holding register stays occupied.
    assign load_ok    = load_req && (!hold_full_q || xfer);
    assign load_drop  = load_req && hold_full_q && !xfer;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_d      = last_shift;
        overrun_d   = overrun_q;

        if (xfer) begin
            shift_d     = hold_q;
            cnt_d       = '0;
            state_d     = ST_SHIFT;
            hold_full_d = 1'b0;
        end else if (last_shift) begin
            shift_d = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else if ((state_q == ST_SHIFT) && shift_req) begin
            shift_d = shift_adv;
            cnt_d   = cnt_q + 1'b1;
        end

        // Applied after the transfer so a same-cycle reload keeps hold_full set.
        if (load_ok) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
        end

        // A drop in the same cycle as a clear leaves the flag set.
        if (load_drop) begin
            overrun_d = 1'b1;
        end else if (bus.select && bus.clr_ovr) begin
            overrun_d = 1'b0;
        end

        busy_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.sout      = shift_q[0];
    assign bus.busy      = busy_q;
    assign bus.hold_full = hold_full_q;
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_shift_pin_sout_fsm.sv
// Self-checking bench for shift_pin_sout_fsm (WIDTH = 8): a directed vector
// table, hand-written multi-cycle sequences, and a randomized run, all
// compared each cycle against a word/bit-queue reference model.
module tb_shift_pin_sout_fsm;

    localparam int W = 8;

    logic clk;
    logic reset;

    shift_pin_sout_fsm_if #(.WIDTH(W)) bus ();

    shift_pin_sout_fsm #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: bits of the word on the wire (front = current sout),
    // pending words in the holding register, sticky overrun, done pulse.
    bit            m_cur[$];
    logic [0:W-1]  m_hold[$];
    bit            m_ovr;
    bit            m_done;

    // Receiver / bookkeeping.
    logic [31:0]   acc;
    logic [0:W-1]  rx;
    int            done_cnt;

    task automatic model_step(input bit rst, input bit sel, input bit ld,
                              input logic [0:W-1] d, input bit sh, input bit clr);
        bit busy, fin, had, xfer, drop;
        logic [0:W-1] w;
        if (rst) begin
            m_cur.delete();
            m_hold.delete();
            m_ovr  = 1'b0;
            m_done = 1'b0;
            return;
        end
        busy = (m_cur.size() != 0);
        fin  = busy && sel && sh && (m_cur.size() == 1);
        if (busy && sel && sh) void'(m_cur.pop_front());
        m_done = fin;
        had  = (m_hold.size() != 0);
        xfer = had && (!busy || fin);
        if (xfer) begin
            w = m_hold.pop_front();
            for (int i = 0; i < W; i++) m_cur.push_back(w[i]);
        end
        drop = sel && ld && had && !xfer;
        if (sel && ld && !drop) m_hold.push_back(d);
        if (drop) m_ovr = 1'b1;
        else if (sel && clr) m_ovr = 1'b0;
    endtask

    function automatic logic [4:0] model_out();
        logic s;
        s = (m_cur.size() != 0) ? m_cur[0] : 1'b0;
        return {s, (m_cur.size() != 0), (m_hold.size() != 0), m_done, m_ovr};
    endfunction

    function automatic logic [4:0] dut_out();
        return {bus.sout, bus.busy, bus.hold_full, bus.done, bus.overrun};
    endfunction

    task automatic check5(input string nm, input logic [4:0] got, input logic [4:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (sout,busy,hold_full,done,overrun)", nm, got, exp);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance model, compare after the edge.
    task automatic step(input bit rst, input bit sel, input bit ld,
                        input logic [0:W-1] d, input bit sh, input bit clr,
                        input string nm);
        logic pre_sout;
        bit   pre_busy;
        reset       = rst;
        bus.select  = sel;
        bus.load    = ld;
        bus.din     = d;
        bus.shift   = sh;
        bus.clr_ovr = clr;
        pre_sout = bus.sout;
        pre_busy = (m_cur.size() != 0);
        model_step(rst, sel, ld, d, sh, clr);
        @(posedge clk);
        #1;
        if (!rst && sel && sh && pre_busy) begin
            acc = {acc[30:0], pre_sout};
            rx  = {rx[1:W-1], pre_sout};
        end
        if (bus.done === 1'b1) done_cnt++;
        check5(nm, dut_out(), model_out());
    endtask

    task automatic idle(input string nm);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, nm);
    endtask

    task automatic load_w(input logic [0:W-1] d, input string nm);
        step(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0, nm);
    endtask

    task automatic shift_n(input int n, input string nm);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, nm);
    endtask

    task automatic clear_rx();
        acc      = '0;
        rx       = '0;
        done_cnt = 0;
    endtask

    typedef struct {
        bit           rst;
        bit           sel;
        bit           ld;
        logic [0:W-1] d;
        bit           sh;
        bit           clr;
        logic [4:0]   exp;  // {sout, busy, hold_full, done, overrun}
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit sel, input bit ld,
                                input logic [0:W-1] d, input bit sh, input bit clr,
                                input logic [4:0] exp);
        vec_t v;
        v.rst = rst; v.sel = sel; v.ld = ld; v.d = d;
        v.sh = sh; v.clr = clr; v.exp = exp;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        int busy_low;
        reset       = 1'b1;
        bus.select  = 1'b0;
        bus.load    = 1'b0;
        bus.din     = '0;
        bus.shift   = 1'b0;
        bus.clr_ovr = 1'b0;
        clear_rx();
        m_ovr  = 1'b0;
        m_done = 1'b0;

        // ---- Directed vector table: single word 1011_0010, then gating ----
        tbl[0]  = mk(1, 0, 0, 8'h00, 0, 0, 5'b00000);
        tbl[1]  = mk(0, 1, 1, 8'hB2, 0, 0, 5'b00100);
        tbl[2]  = mk(0, 1, 0, 8'h00, 0, 0, 5'b11000);
        tbl[3]  = mk(0, 1, 0, 8'h00, 1, 0, 5'b01000);
        tbl[4]  = mk(0, 1, 0, 8'h00, 1, 0, 5'b11000);
        tbl[5]  = mk(0, 1, 0, 8'h00, 1, 0, 5'b11000);
        tbl[6]  = mk(0, 1, 0, 8'h00, 1, 0, 5'b01000);
        tbl[7]  = mk(0, 1, 0, 8'h00, 1, 0, 5'b01000);
        tbl[8]  = mk(0, 1, 0, 8'h00, 1, 0, 5'b11000);
        tbl[9]  = mk(0, 1, 0, 8'h00, 1, 0, 5'b01000);
        tbl[10] = mk(0, 1, 0, 8'h00, 1, 0, 5'b00010);
        tbl[11] = mk(0, 1, 0, 8'h00, 0, 0, 5'b00000);
        tbl[12] = mk(0, 0, 1, 8'hFF, 1, 1, 5'b00000);
        tbl[13] = mk(0, 0, 1, 8'h5A, 0, 0, 5'b00000);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].sel, tbl[i].ld, tbl[i].d, tbl[i].sh, tbl[i].clr,
                 $sformatf("table_model[%0d]", i));
            check5($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        // ---- Back-to-back A5 then 3C ----
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "b2b_reset");
        load_w(8'hA5, "b2b_load_a5");
        idle("b2b_xfer");
        load_w(8'h3C, "b2b_load_3c");
        clear_rx();
        busy_low = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, "b2b_shift");
            if (i < 15 && bus.busy !== 1'b1) busy_low++;
        end
        check_val("b2b_bits", {16'h0, acc[15:0]}, 32'h0000_A53C);
        check_val("b2b_busy_gap", busy_low, 0);
        check_val("b2b_done_pulses", done_cnt, 2);
        check_val("b2b_overrun", {31'h0, bus.overrun}, 0);

        // ---- Overrun: 11 shifting, 22 held, 33 dropped ----
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "ovr_reset");
        load_w(8'h11, "ovr_load_11");
        idle("ovr_xfer");
        load_w(8'h22, "ovr_load_22");
        load_w(8'h33, "ovr_load_33");
        check_val("ovr_set", {31'h0, bus.overrun}, 1);
        clear_rx();
        shift_n(16, "ovr_shift");
        check_val("ovr_bits", {16'h0, acc[15:0]}, 32'h0000_1122);
        check_val("ovr_sticky", {31'h0, bus.overrun}, 1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, "ovr_clr");
        check_val("ovr_cleared", {31'h0, bus.overrun}, 0);

        // ---- Load coinciding with final shift while hold is full ----
        load_w(8'h55, "sim_load_55");
        idle("sim_xfer");
        load_w(8'h66, "sim_load_66");
        shift_n(7, "sim_shift");
        step(1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, "sim_final_and_load");
        check_val("sim_hold_full", {31'h0, bus.hold_full}, 1);
        check_val("sim_no_overrun", {31'h0, bus.overrun}, 0);
        clear_rx();
        shift_n(16, "sim_shift2");
        check_val("sim_bits", {16'h0, acc[15:0]}, 32'h0000_6677);

        // ---- Select gating with loopback receiver ----
        load_w(8'hC3, "gate_load");
        idle("gate_xfer");
        clear_rx();
        for (int i = 0; i < W; i++) begin
            step(1'b0, 1'b0, 1'b1, W'($urandom), 1'b1, 1'b1, "gate_unselected");
            step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, "gate_shift");
        end
        check_val("gate_loopback", {24'h0, rx}, 32'h0000_00C3);
        check_val("gate_done", done_cnt, 1);

        // ---- Reset in the middle of a word ----
        load_w(8'hFF, "rst_load_ff");
        idle("rst_xfer");
        shift_n(3, "rst_shift");
        step(1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, "rst_mid");
        check5("rst_mid_outputs", dut_out(), 5'b00000);
        load_w(8'h81, "rst_load_81");
        check_val("rst_first_load", {31'h0, bus.hold_full}, 1);
        idle("rst_xfer2");
        clear_rx();
        shift_n(W, "rst_shift2");
        check_val("rst_word_81", {24'h0, rx}, 32'h0000_0081);
        check_val("rst_done", done_cnt, 1);

        // ---- Randomized run against the model ----
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 250) == 0, ($urandom % 8) != 0, ($urandom % 5) == 0,
                 W'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_pin_sout_fsm.md
SHIFT_PIN_SOUT_FSM -- requirements
Module: shift_pin_sout_fsm

Interface
REQ-001 Parameter WIDTH, default 8, bits per word; SHALL be >= 2; bit vectors indexed [0:WIDTH-1].
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 select  input  1  qualifies load, shift and clr_ovr; SHALL be ignored when low.
REQ-005 load  input  1  write din into holding register.
REQ-006 din  input  [0:WIDTH-1]  parallel word to transmit.
REQ-007 shift  input  1  advance serial output by one bit.
REQ-008 clr_ovr  input  1  clear sticky overrun flag.
REQ-009 sout  output  1  serial data, registered.
REQ-010 busy  output  1  high while a word is being shifted out.
REQ-011 hold_full  output  1  holding register occupied.
REQ-012 done  output  1  one-cycle pulse after last bit of a word is shifted.
REQ-013 overrun  output  1  sticky; a load was dropped.

Function
REQ-014 Bit order SHALL be index 0 first, index WIDTH-1 last, so a receiver shifting {q[1:WIDTH-1], sin} reproduces the word at identical indices.
REQ-015 Storage: holding register hold_q, shift register shift_q, bit counter cnt (0..WIDTH-1), state IDLE/SHIFT.
REQ-016 sout SHALL equal shift_q[0] at all times; shift_q SHALL be zero in IDLE.
REQ-017 Load accept: select & load & (hold_full==0 or transfer this cycle) -> hold_q<=din, hold_full<=1.
REQ-018 Load drop: select & load & hold_full==1 & no transfer this cycle -> hold_q unchanged, overrun<=1.
REQ-019 Transfer: IDLE & hold_full==1 -> shift_q<=hold_q, cnt<=0, state SHIFT, busy<=1, hold_full<=0 (unless REQ-017 reloads it same cycle).
REQ-020 SHIFT & select & shift & cnt<WIDTH-1 -> shift_q<={shift_q[1:WIDTH-1],0}, cnt<=cnt+1.
REQ-021 SHIFT & select & shift & cnt==WIDTH-1 -> done<=1 next cycle; if hold_full==1, back-to-back transfer (shift_q<=hold_q, cnt<=0, stay SHIFT, busy stays 1); else shift_q<=0, state IDLE, busy<=0.
REQ-022 SHIFT without qualified shift: shift_q, cnt, sout SHALL hold.
REQ-023 done SHALL be high for exactly one cycle per completed word, otherwise low.
REQ-024 Latency: load accepted at edge N in IDLE with empty hold -> hold_full=1 after N; transfer at N+1; sout=din[0], busy=1 after N+1.
REQ-025 Simultaneous load and final shift with hold_full==1: transfer of old hold_q and acceptance of new din SHALL both occur; no overrun.
REQ-026 select & clr_ovr -> overrun<=0; if an overrun drop occurs same cycle, set SHALL win.
REQ-027 cnt SHALL never exceed WIDTH-1; no wrap outside REQ-021.

Reset
REQ-028 reset SHALL dominate all inputs, including mid-word: state IDLE, cnt=0, shift_q=0, hold_q=0, sout=0, busy=0, hold_full=0, done=0, overrun=0 after the edge.
REQ-029 After reset deassertion the block SHALL accept a load on the first cycle.

Verification
REQ-030 Single word: load din=8'b1011_0010, 8 shifts -> sout 1,0,1,1,0,0,1,0 (one bit per shift), done pulse once, busy falls, hold_full=0.
REQ-031 Back-to-back: load 8'hA5, load 8'h3C during shifting, 16 shifts -> 16 bits A5 then 3C with no gap, busy continuous high, two done pulses, overrun=0.
REQ-032 Overrun: load 8'h11 (shifting), load 8'h22 (held), load 8'h33 before final shift -> overrun=1, 8'h33 never transmitted; clr_ovr -> overrun=0.
REQ-033 Select gating: select=0 with load/shift/clr_ovr toggling -> no state change; loopback into receiver word equals din.
REQ-034 Reset mid-word: assert reset after 3 shifts of 8'hFF -> next cycle sout=0, busy=0, hold_full=0, done=0; fresh load 8'h81 transmits correctly.
